// File: rtl/vga_timing_if.sv
// Purpose : bundles the raster counters, compositor pixel return path and
//           physical VGA pins of vga_timing_output into one port.
// Ports   : master = timing generator (drives counters, pins, strobes; reads
//           pixel_in); slave = compositor/board side (the reverse).
interface vga_timing_if #(
  parameter int INPUT_WIDTH = 10,
  parameter int PIXEL_SIZE  = 16
);
  logic [INPUT_WIDTH-1:0] h_count;
  logic [INPUT_WIDTH-1:0] v_count;
  logic [PIXEL_SIZE-1:0]  pixel_in;
  logic [7:0]             vga_r;
  logic [7:0]             vga_g;
  logic [7:0]             vga_b;
  logic                   vga_hs;
  logic                   vga_vs;
  logic                   vga_blank_n;
  logic                   vga_sync_n;
  logic                   vga_clk;
  logic                   vblank;
  logic                   frame_start;
  logic [15:0]            frame_count;

  modport master (
    output h_count, v_count, vga_r, vga_g, vga_b, vga_hs, vga_vs,
           vga_blank_n, vga_sync_n, vga_clk, vblank, frame_start, frame_count,
    input  pixel_in
  );

  modport slave (
    input  h_count, v_count, vga_r, vga_g, vga_b, vga_hs, vga_vs,
           vga_blank_n, vga_sync_n, vga_clk, vblank, frame_start, frame_count,
    output pixel_in
  );
endinterface

// File: rtl/vga_timing_output.sv
// Purpose : 640x480 VGA raster generator plus DAC output stage that re-aligns
//           syncs/blank to the compositor's pipeline and expands RGB555 to 8 bits.
// Latency : vga_* pins lag h_count/v_count by PIPE_DELAY+1 clk; strobes coincide with counters.
// Backpr. : none -- free-running raster, pixel_in is sampled every clk.
// Ports   : clk, rst (async active-high); vif (master modport of vga_timing_if):
//           h_count/v_count out, pixel_in in, vga_r/g/b/hs/vs/blank_n/sync_n/clk out,
//           vblank/frame_start/frame_count out.
module vga_timing_output #(
  parameter int INPUT_WIDTH = 10,
  parameter int PIXEL_SIZE  = 16,
  parameter int CLK_DIV     = 2,   // clk cycles per pixel tick, 1..4
  parameter int PIPE_DELAY  = 1    // compositor delay in clk cycles, 0..7
) (
  input  logic         clk,
  input  logic         rst,
  vga_timing_if.master vif
);

  typedef logic [INPUT_WIDTH-1:0] cnt_t;

  localparam cnt_t H_LAST      = cnt_t'(799);
  localparam cnt_t V_LAST      = cnt_t'(524);
  localparam cnt_t H_SYNC_END  = cnt_t'(96);
  localparam cnt_t V_SYNC_END  = cnt_t'(2);
  localparam cnt_t H_ACT_FIRST = cnt_t'(144);
  localparam cnt_t H_ACT_LAST  = cnt_t'(783);
  localparam cnt_t V_ACT_FIRST = cnt_t'(33);
  localparam cnt_t V_ACT_LAST  = cnt_t'(512);
  localparam cnt_t V_FP_FIRST  = cnt_t'(513);

  localparam logic [1:0] DIV_LAST = 2'(CLK_DIV - 1);

  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, act: 1'b0};

  // RGB555 field to 8 bits: replicate the MSBs into the low bits so full
  // scale maps to 8'hFF and zero stays zero.
  function automatic logic [7:0] expand5(input logic [4:0] f);
    return {f, f[4:2]};
  endfunction

  // ---------------------------------------------------------------- state
  logic [1:0]  div_q, div_d;
  cnt_t        h_count_q, h_count_d;
  cnt_t        v_count_q, v_count_d;
  logic        vga_clk_q, vga_clk_d;
  logic        frame_start_q, frame_start_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic [7:0]  vga_r_q, vga_r_d;
  logic [7:0]  vga_g_q, vga_g_d;
  logic [7:0]  vga_b_q, vga_b_d;
  logic        vga_hs_q, vga_hs_d;
  logic        vga_vs_q, vga_vs_d;
  logic        vga_blank_n_q, vga_blank_n_d;

  logic                  tick;
  sync_t                 sync_raw;
  sync_t                 sync_dly;
  logic [PIXEL_SIZE-1:0] pix;
  logic                  pix_on;

  assign pix  = vif.pixel_in;
  assign tick = (div_q == DIV_LAST);

  // ------------------------------------------------------ raster counters
  always_comb begin
    div_d         = tick ? 2'd0 : div_q + 2'd1;
    h_count_d     = h_count_q;
    v_count_d     = v_count_q;
    frame_count_d = frame_count_q;
    frame_start_d = 1'b0;
    vga_clk_d     = tick;   // registered so it rises with the counter update
    if (tick) begin
      if (h_count_q == H_LAST) begin
        h_count_d = '0;
        if (v_count_q == V_LAST) begin
          v_count_d     = '0;
          frame_start_d = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
        end else begin
          v_count_d = v_count_q + cnt_t'(1);
        end
      end else begin
        h_count_d = h_count_q + cnt_t'(1);
      end
    end
  end

  // Undelayed timing decoded from the counters as they leave this block.
  always_comb begin
    sync_raw.hs  = (h_count_q >= H_SYNC_END);
    sync_raw.vs  = (v_count_q >= V_SYNC_END);
    sync_raw.act = (h_count_q >= H_ACT_FIRST) && (h_count_q <= H_ACT_LAST) &&
                   (v_count_q >= V_ACT_FIRST) && (v_count_q <= V_ACT_LAST);
  end

  // ------------------------------------------ compositor-delay alignment
  // Syncs and blank travel alongside the pixel through the compositor's
  // pipeline so that each pixel meets its own timing at the output register.
  if (PIPE_DELAY == 0) begin : g_bypass
    assign sync_dly = sync_raw;
  end else begin : g_pipe
    sync_t pipe_q [PIPE_DELAY];
    sync_t pipe_d [PIPE_DELAY];

    always_comb begin
      pipe_d[0] = sync_raw;
      for (int i = 1; i < PIPE_DELAY; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < PIPE_DELAY; i++) begin
          pipe_q[i] <= SYNC_IDLE;
        end
      end else begin
        pipe_q <= pipe_d;
      end
    end

    assign sync_dly = pipe_q[PIPE_DELAY-1];
  end

  // ------------------------------------------------------ output register
  always_comb begin
    // Invalid compositor pixels show black; blanking always wins.
    pix_on        = sync_dly.act && pix[0];
    vga_hs_d      = sync_dly.hs;
    vga_vs_d      = sync_dly.vs;
    vga_blank_n_d = sync_dly.act;
    vga_r_d       = pix_on ? expand5(pix[15:11]) : 8'd0;
    vga_g_d       = pix_on ? expand5(pix[10:6])  : 8'd0;
    vga_b_d       = pix_on ? expand5(pix[5:1])   : 8'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q         <= 2'd0;
      h_count_q     <= '0;
      v_count_q     <= '0;
      vga_clk_q     <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= 16'd0;
      vga_r_q       <= 8'd0;
      vga_g_q       <= 8'd0;
      vga_b_q       <= 8'd0;
      vga_hs_q      <= 1'b1;
      vga_vs_q      <= 1'b1;
      vga_blank_n_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      h_count_q     <= h_count_d;
      v_count_q     <= v_count_d;
      vga_clk_q     <= vga_clk_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
      vga_r_q       <= vga_r_d;
      vga_g_q       <= vga_g_d;
      vga_b_q       <= vga_b_d;
      vga_hs_q      <= vga_hs_d;
      vga_vs_q      <= vga_vs_d;
      vga_blank_n_q <= vga_blank_n_d;
    end
  end

  // ------------------------------------------------------------- outputs
  assign vif.h_count     = h_count_q;
  assign vif.v_count     = v_count_q;
  assign vif.vga_r       = vga_r_q;
  assign vif.vga_g       = vga_g_q;
  assign vif.vga_b       = vga_b_q;
  assign vif.vga_hs      = vga_hs_q;
  assign vif.vga_vs      = vga_vs_q;
  assign vif.vga_blank_n = vga_blank_n_q;
  assign vif.vga_sync_n  = 1'b0;
  assign vif.vga_clk     = vga_clk_q;
  assign vif.frame_start = frame_start_q;
  assign vif.frame_count = frame_count_q;
  // Taken from the live counters so loaders see it aligned with h/v_count.
  assign vif.vblank      = (v_count_q >= V_FP_FIRST) || (v_count_q < V_ACT_FIRST);

endmodule

// File: doc/vga_timing_output.md
# vga_timing_output

Generates the 640x480 VGA raster (h_count/v_count) that drives the sprite/background compositor, and turns the compositor's registered 16-bit pixel back into DAC-ready RGB with sync and blank strobes re-aligned to the compositor's pipeline delay. It sits on both sides of the compositor: counters out to it, its pixel back in, physical VGA pins out to the board DAC. It also supplies frame-level strobes (vblank, frame_start, frame counter) used by the game-state loaders.

## Interface
Parameters:
- INPUT_WIDTH, 10, width of h_count/v_count
- PIXEL_SIZE, 16, compositor pixel width
- CLK_DIV, 2, clk cycles per pixel tick (legal 1..4)
- PIPE_DELAY, 1, clk cycles from counter change to matching pixel at pixel_in (legal 0..7)

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- h_count  output  INPUT_WIDTH  horizontal position, 0..799
- v_count  output  INPUT_WIDTH  vertical line, 0..524
- pixel_in  input  PIXEL_SIZE  compositor pixel: [15:11] R, [10:6] G, [5:1] B, [0] valid
- vga_r, vga_g, vga_b  output  8 each  DAC colour
- vga_hs, vga_vs  output  1 each  syncs, active-low
- vga_blank_n  output  1  low outside active area
- vga_sync_n  output  1  constant 0
- vga_clk  output  1  pixel tick (high for first clk of each tick)
- vblank  output  1  high while v_count >= 513 or v_count < 33 (undelayed)
- frame_start  output  1  one-clk pulse when v_count wraps 524->0
- frame_count  output  16  frames since reset, wraps

## Operation
- Tick divider: div counter 0..CLK_DIV-1, increments every clk; tick when div == CLK_DIV-1. CLK_DIV=1: tick every clk.
- On tick: h_count increments; 799 -> 0 and v_count increments; v_count 524 -> 0.
- Horizontal: sync 0-95, back porch 96-143, active 144-783, front porch 784-799.
- Vertical: sync 0-1, back porch 2-32, active 33-512, front porch 513-524.
- Raw (undelayed) signals, combinational from counters: hs_raw = !(h<96); vs_raw = !(v<2); act_raw = (144<=h<=783) && (33<=v<=512).
- Alignment: hs_raw, vs_raw, act_raw pass through a PIPE_DELAY-deep clk shift register; PIPE_DELAY=0 is a bypass.
- Output register (every clk): vga_hs/vga_vs <= delayed syncs; vga_blank_n <= delayed act; if delayed act && pixel_in[0] then R/G/B = 5-bit field replicated {f, f[4:2]}, else 0.
- Pixel with valid=0 inside active area outputs black; blank always forces 0 regardless of pixel_in.
- frame_start: asserted for exactly one clk, the clk in which the tick moves (h,v) from (799,524) to (0,0); frame_count increments same clk.
- vblank derived from current counters (not delayed) so loaders see it coincident with the counters they observe.

## Timing
- Reset values: h_count=0, v_count=0, div=0, shift registers=idle (hs=1, vs=1, act=0), vga_r/g/b=0, vga_hs=1, vga_vs=1, vga_blank_n=0, vga_clk=0, frame_start=0, frame_count=0, vblank=1 (v=0).
- Reset mid-frame: all state returns immediately; first tick after release occurs CLK_DIV clks after rst falls; no frame_start on reset itself.
- Latency: vga_* pins lag counters by PIPE_DELAY+1 clks; pixel_in is sampled in the clk its delayed act arrives.
- Line = 800 ticks, frame = 420000 ticks = 420000*CLK_DIV clks.
- vga_clk high one clk per tick, registered, coincident with counter update; CLK_DIV=1 gives vga_clk held high.
- vga_sync_n is tied 0 including during reset.

## Test plan
- Reset release, CLK_DIV=2: h_count reaches 1 at clk 2, 799->0 after 1600 clks, v_count=1 at same clk; frame_start once after 840000 clks, frame_count=1.
- Sync widths, PIPE_DELAY=1: vga_hs low exactly 96 ticks per line, vga_vs low exactly 2 lines; both edges lag counter transitions by 2 clks.
- Blank/pixel: drive pixel_in=16'hFFFF constantly -> vga_r/g/b=8'hFF only for 640x480 pixels per frame, 0 elsewhere; pixel_in=16'hFFFE -> all 0 in active area.
- Colour expansion: pixel_in = R=5'b10000,G=0,B=5'b11111,valid=1 -> vga_r=8'h84, vga_g=0, vga_b=8'hFF.
- PIPE_DELAY sweep 0,1,3: first vga_blank_n rise at h=144,v=33 arrives PIPE_DELAY+1 clks after counters reach it.
- Async reset asserted at h=400,v=200 mid-clk: outputs reach reset values before next edge; after release counting restarts at (0,0) with no spurious frame_start.
